wb_stage: RTL

Write-back stage of the five-stage MIPS pipeline. It accepts retiring instructions from the memory stage over a valid/allowin handshake and waits for load data from the data SRAM. It also aligns and extends load data, then drives the register file write port (wen/waddr/wdata) exactly once per instruction. It publishes forwarding/stall information to decode and the golden-trace debug signals used by the verification environment.

---
 rtl/wb_stage_pkg.sv | 25 ++
 rtl/load_align.sv | 39 +++
 rtl/wb_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: widths, load opcodes and FSM states.
package wb_stage_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_READY     = 2'd2
    } ws_state_e;

    // Opcodes 6 and 7 are not loads; they retire like ALU results.
    function automatic logic is_load(input logic [2:0] op);
        return (op >= LD_LB) && (op <= LD_LW);
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: selects byte/halfword/word from a raw
// 32-bit memory word and sign- or zero-extends it.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  ld_op_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
    end

    // Halfword accesses are always aligned, so only addr_lo[1] matters.
    assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        result_o = word_i;
        case (ld_op_i)
            LD_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  result_o = {24'd0, byte_sel};
            LD_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  result_o = {16'd0, half_sel};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: holds one retiring instruction, waits for load data,
// drives the register file write port and publishes forwarding/debug info.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ms_valid,
    output logic                  ws_allowin,
    input  logic [31:0]           ms_pc,
    input  logic                  ms_wen,
    input  logic [ADDR_WIDTH-1:0] ms_waddr,
    input  logic [DATA_WIDTH-1:0] ms_result,
    input  logic [2:0]            ms_ld_op,
    input  logic [1:0]            ms_addr_lo,

    input  logic                  data_rvalid,
    input  logic [31:0]           data_rdata,

    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,

    output logic                  fwd_valid,
    output logic [ADDR_WIDTH-1:0] fwd_addr,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  fwd_stall,

    output logic [31:0]           debug_wb_pc,
    output logic [3:0]            debug_wb_rf_wen,
    output logic [ADDR_WIDTH-1:0] debug_wb_rf_wnum,
    output logic [31:0]           debug_wb_rf_wdata
);

    ws_state_e             state_q;
    logic [31:0]           pc_q;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [2:0]            ld_op_q;
    logic [1:0]            addr_lo_q;
    logic [31:0]           ld_word_q;

    logic                  accept;
    logic                  ws_valid;
    logic                  live_write;
    logic [31:0]           aligned;
    logic [DATA_WIDTH-1:0] wdata;

    assign ws_allowin = (state_q != ST_WAIT_DATA);
    assign accept     = ms_valid && ws_allowin;

    // A READY instruction always retires; the slot is refilled on the same edge
    // when a new instruction is accepted, so back-to-back flow has no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            pc_q      <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            result_q  <= '0;
            ld_op_q   <= LD_NONE;
            addr_lo_q <= '0;
            ld_word_q <= '0;
        end else begin
            case (state_q)
                ST_WAIT_DATA: begin
                    if (data_rvalid) begin
                        ld_word_q <= data_rdata;
                        state_q   <= ST_READY;
                    end
                end
                default: begin
                    if (accept) begin
                        pc_q      <= ms_pc;
                        wen_q     <= ms_wen;
                        waddr_q   <= ms_waddr;
                        result_q  <= ms_result;
                        ld_op_q   <= ms_ld_op;
                        addr_lo_q <= ms_addr_lo;
                        state_q   <= is_load(ms_ld_op) ? ST_WAIT_DATA : ST_READY;
                    end else begin
                        state_q   <= ST_EMPTY;
                    end
                end
            endcase
        end
    end

    load_align u_load_align (
        .word_i    (ld_word_q),
        .ld_op_i   (ld_op_q),
        .addr_lo_i (addr_lo_q),
        .result_o  (aligned)
    );

    assign ws_valid   = (state_q != ST_EMPTY);
    assign live_write = wen_q && (waddr_q != '0);
    assign wdata      = is_load(ld_op_q) ? aligned : result_q;

    assign rf_wen   = (state_q == ST_READY) && live_write;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata;

    assign fwd_valid = ws_valid && live_write;
    assign fwd_addr  = waddr_q;
    assign fwd_data  = wdata;
    assign fwd_stall = fwd_valid && (state_q == ST_WAIT_DATA);

    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_wen   = {4{rf_wen}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule
